// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: accepts one EX request at a time, drives a synchronous
// word-wide data RAM with byte enables, and returns extended load data or an exception.
module lsu_mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_is_load,
    output logic [1:0]        rsp_exc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [1:0] EXC_OK    = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_F3    = 2'b10;
    localparam logic [1:0] EXC_RANGE = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_legal;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic [1:0]          w_exc;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_addr_lo;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic [31:0]         r_rsp_data;
    logic [4:0]          r_rsp_rd;
    logic                r_rsp_is_load;
    logic [1:0]          r_rsp_exc;

    assign req_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = req_valid && req_ready;

    // Request checks, evaluated on the live request so the outcome is known at acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_legal = 1'b0;
        if (req_we) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_out_of_range = |req_addr[31:ADDR_W+2];
        if (!w_legal) begin
            w_exc = EXC_F3;
        end else if (w_misaligned) begin
            w_exc = EXC_ALIGN;
        end else if (w_out_of_range) begin
            w_exc = EXC_RANGE;
        end else begin
            w_exc = EXC_OK;
        end
    end

    // Lane formatting: data is replicated across lanes and the byte enables pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = ram_rdata[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = ram_rdata[15:8];
            2'd2:    w_byte = ram_rdata[23:16];
            2'd3:    w_byte = ram_rdata[31:24];
            default: ;
        endcase
        w_half = r_addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_exc != EXC_OK) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS:  w_next = r_we ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr_lo     <= 2'd0;
            r_be          <= 4'd0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= 32'd0;
            r_rsp_data    <= 32'd0;
            r_rsp_rd      <= 5'd0;
            r_rsp_is_load <= 1'b0;
            r_rsp_exc     <= 2'd0;
        end else begin
            if (w_accept) begin
                r_we          <= req_we;
                r_funct3      <= req_funct3;
                r_addr_lo     <= req_addr[1:0];
                r_be          <= w_be;
                r_ram_addr    <= req_addr[ADDR_W+1:2];
                r_ram_wdata   <= w_wdata;
                r_rsp_data    <= 32'd0;
                r_rsp_rd      <= req_rd;
                r_rsp_is_load <= !req_we;
                r_rsp_exc     <= w_exc;
            end
            if (r_state == S_CAPTURE) begin
                r_rsp_data <= w_load_data;
            end
        end
    end

    // Write strobe is gated by rst_n combinationally so a reset landing on ACCESS blocks the write.
    assign ram_we      = (r_state == S_ACCESS) && r_we && rst_n;
    assign ram_be      = (r_state == S_ACCESS) ? r_be : 4'd0;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_rd      = r_rsp_rd;
    assign rsp_is_load = r_rsp_is_load;
    assign rsp_exc     = r_rsp_exc;

endmodule
